// File: rtl/aclk_alarm_seq_if.sv
// Signal bundle between the alarm clock core (time, ticks, buttons) and the alarm sequencer.
// The master side drives time, ticks and buttons; the slave side returns the sound/status outputs.
interface aclk_alarm_seq_if;
    logic       one_second;
    logic       one_minute;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic [3:0] alarm_time_ms_hr;
    logic [3:0] alarm_time_ls_hr;
    logic [3:0] alarm_time_ms_min;
    logic [3:0] alarm_time_ls_min;
    logic       alarm_arm;
    logic       snooze_button;
    logic       stop_button;
    logic       alarm_sound;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_count;

    modport master (
        output one_second, one_minute,
        output current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
        output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
        output alarm_arm, snooze_button, stop_button,
        input  alarm_sound, ringing, snoozing, snooze_count
    );

    modport slave (
        input  one_second, one_minute,
        input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min,
        input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min,
        input  alarm_arm, snooze_button, stop_button,
        output alarm_sound, ringing, snoozing, snooze_count
    );
endinterface

// File: rtl/aclk_alarm_seq.sv
// Alarm sequencer: detects the alarm-time match and runs ring / snooze / stop with a ring timeout.
// Optional ACLK_ALARM_BEEP_EN: pulse the sound 1 s on / 1 s off instead of a steady tone.
module aclk_alarm_seq #(
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned SNOOZE_MIN       = 5,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic             clock,
    input  logic             reset,
    aclk_alarm_seq_if.slave  bus
);

    localparam logic [7:0] RING_TIMEOUT_V = 8'(RING_TIMEOUT_SEC);
    localparam logic [3:0] SNOOZE_MIN_V   = 4'(SNOOZE_MIN);
    localparam logic [2:0] MAX_SNOOZE_V   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    function automatic logic bcd_time_equal(
        input logic [3:0] a_mh, input logic [3:0] a_lh, input logic [3:0] a_mm, input logic [3:0] a_lm,
        input logic [3:0] b_mh, input logic [3:0] b_lh, input logic [3:0] b_mm, input logic [3:0] b_lm
    );
        return (a_mh == b_mh) && (a_lh == b_lh) && (a_mm == b_mm) && (a_lm == b_lm);
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       match_s;
    logic       match_q_r;
    logic       trigger_s;
    logic       snooze_prev_r;
    logic       stop_prev_r;
    logic       snooze_press_s;
    logic       stop_press_s;
    logic       can_snooze_s;
    logic [7:0] ring_timer_r;
    logic [7:0] ring_timer_next_s;
    logic [7:0] ring_timer_inc_s;
    logic [3:0] snooze_timer_r;
    logic [3:0] snooze_timer_next_s;
    logic [2:0] snooze_count_r;
    logic [2:0] snooze_count_next_s;
    logic       alarm_sound_r;
    logic       ringing_r;
    logic       snoozing_r;
`ifdef ACLK_ALARM_BEEP_EN
    logic       beep_phase_r;
    logic       beep_phase_next_s;
`endif

    assign match_s = bcd_time_equal(
        bus.current_time_ms_hr, bus.current_time_ls_hr, bus.current_time_ms_min, bus.current_time_ls_min,
        bus.alarm_time_ms_hr,   bus.alarm_time_ls_hr,   bus.alarm_time_ms_min,   bus.alarm_time_ls_min);

    assign trigger_s        = match_s & ~match_q_r & bus.alarm_arm;
    assign snooze_press_s   = bus.snooze_button & ~snooze_prev_r;
    assign stop_press_s     = bus.stop_button & ~stop_prev_r;
    assign can_snooze_s     = (snooze_count_r < MAX_SNOOZE_V);
    assign ring_timer_inc_s = ring_timer_r + 8'd1;

    // Next-state and timer/counter update; priority: disarm, stop, snooze, tick.
    always_comb begin
        state_next_s        = state_r;
        ring_timer_next_s   = ring_timer_r;
        snooze_timer_next_s = snooze_timer_r;
        snooze_count_next_s = snooze_count_r;
`ifdef ACLK_ALARM_BEEP_EN
        beep_phase_next_s   = beep_phase_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_next_s        = ST_RINGING;
                    ring_timer_next_s   = 8'd0;
                    snooze_count_next_s = 3'd0;
`ifdef ACLK_ALARM_BEEP_EN
                    beep_phase_next_s   = 1'b1;
`endif
                end else begin
                    state_next_s        = ST_IDLE;
                end
            end
            ST_RINGING: begin
                if (!bus.alarm_arm || stop_press_s) begin
                    state_next_s        = ST_IDLE;
                    snooze_count_next_s = 3'd0;
                end else if (snooze_press_s && can_snooze_s) begin
                    state_next_s        = ST_SNOOZE;
                    snooze_count_next_s = snooze_count_r + 3'd1;
                    snooze_timer_next_s = SNOOZE_MIN_V;
                end else if (bus.one_second) begin
                    if (ring_timer_inc_s == RING_TIMEOUT_V) begin
                        if (can_snooze_s) begin
                            state_next_s        = ST_SNOOZE;
                            snooze_count_next_s = snooze_count_r + 3'd1;
                            snooze_timer_next_s = SNOOZE_MIN_V;
                        end else begin
                            state_next_s        = ST_IDLE;
                            snooze_count_next_s = 3'd0;
                        end
                    end else begin
                        ring_timer_next_s = ring_timer_inc_s;
`ifdef ACLK_ALARM_BEEP_EN
                        beep_phase_next_s = ~beep_phase_r;
`endif
                    end
                end else begin
                    state_next_s = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (!bus.alarm_arm || stop_press_s) begin
                    state_next_s        = ST_IDLE;
                    snooze_count_next_s = 3'd0;
                end else if (bus.one_minute) begin
                    if (snooze_timer_r == 4'd1) begin
                        state_next_s      = ST_RINGING;
                        ring_timer_next_s = 8'd0;
`ifdef ACLK_ALARM_BEEP_EN
                        beep_phase_next_s = 1'b1;
`endif
                    end else begin
                        snooze_timer_next_s = snooze_timer_r - 4'd1;
                    end
                end else begin
                    state_next_s = ST_SNOOZE;
                end
            end
            default: begin
                state_next_s        = ST_IDLE;
                snooze_count_next_s = 3'd0;
            end
        endcase
    end

    // State, timers, edge-detect history and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            match_q_r      <= 1'b0;
            snooze_prev_r  <= 1'b1;
            stop_prev_r    <= 1'b1;
            ring_timer_r   <= 8'd0;
            snooze_timer_r <= 4'd0;
            snooze_count_r <= 3'd0;
            alarm_sound_r  <= 1'b0;
            ringing_r      <= 1'b0;
            snoozing_r     <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            match_q_r      <= match_s;
            snooze_prev_r  <= bus.snooze_button;
            stop_prev_r    <= bus.stop_button;
            ring_timer_r   <= ring_timer_next_s;
            snooze_timer_r <= snooze_timer_next_s;
            snooze_count_r <= snooze_count_next_s;
            ringing_r      <= (state_next_s == ST_RINGING);
            snoozing_r     <= (state_next_s == ST_SNOOZE);
`ifdef ACLK_ALARM_BEEP_EN
            alarm_sound_r  <= (state_next_s == ST_RINGING) & beep_phase_next_s;
`else
            alarm_sound_r  <= (state_next_s == ST_RINGING);
`endif
        end
    end

`ifdef ACLK_ALARM_BEEP_EN
    // Beep phase starts high on each ring entry and flips on every second of ringing.
    always_ff @(posedge clock) begin
        if (reset) begin
            beep_phase_r <= 1'b0;
        end else begin
            beep_phase_r <= beep_phase_next_s;
        end
    end
`endif

    assign bus.alarm_sound  = alarm_sound_r;
    assign bus.ringing      = ringing_r;
    assign bus.snoozing     = snoozing_r;
    assign bus.snooze_count = snooze_count_r;

endmodule

// File: tb/tb_aclk_alarm_seq.sv
// Directed self-checking bench for aclk_alarm_seq with default parameters (60 s, 5 min, 3 snoozes).
module tb_aclk_alarm_seq;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    aclk_alarm_seq_if bus ();

    aclk_alarm_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_current(input logic [3:0] mh, input logic [3:0] lh, input logic [3:0] mm, input logic [3:0] lm);
        bus.current_time_ms_hr  = mh;
        bus.current_time_ls_hr  = lh;
        bus.current_time_ms_min = mm;
        bus.current_time_ls_min = lm;
    endtask

    // Current time 07:29 then 07:30 against alarm 07:30: ringing from the second step.
    task automatic ring_up();
        set_current(4'd0, 4'd7, 4'd2, 4'd9);
        step();
        set_current(4'd0, 4'd7, 4'd3, 4'd0);
        step();
    endtask

    task automatic minute_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.one_minute = 1'b1;
            step();
            bus.one_minute = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.snooze_button = 1'b1;
        bus.stop_button   = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing got %b want 0", bus.ringing); end
        checks++; if (bus.alarm_sound !== 1'b0) begin errors++; $display("FAIL reset_sound got %b want 0", bus.alarm_sound); end
        checks++; if (bus.snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing got %b want 0", bus.snoozing); end
        checks++; if (bus.snooze_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.snooze_count); end
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.alarm_arm = 1'b1;
        set_current(4'd0, 4'd7, 4'd2, 4'd9);
        step();
        checks++; if (bus.ringing !== 1'b0) begin errors++; $display("FAIL basic_before got %b want 0", bus.ringing); end
        set_current(4'd0, 4'd7, 4'd3, 4'd0);
        step();
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL basic_ring got %b want 1", bus.ringing); end
        checks++; if (bus.alarm_sound !== 1'b1) begin errors++; $display("FAIL basic_sound got %b want 1", bus.alarm_sound); end
        step();
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL basic_no_retrigger got %b want 1", bus.ringing); end
        bus.stop_button = 1'b1;
        step();
        bus.stop_button = 1'b0;
        checks++; if (bus.ringing !== 1'b0) begin errors++; $display("FAIL basic_stop got %b want 0", bus.ringing); end
        checks++; if (bus.snooze_count !== 3'd0) begin errors++; $display("FAIL basic_stop_count got %0d want 0", bus.snooze_count); end
        step();
    endtask

    task automatic test_snooze();
        ring_up();
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL snooze_ring got %b want 1", bus.ringing); end
        bus.snooze_button = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        checks++; if (bus.snoozing !== 1'b1) begin errors++; $display("FAIL snooze_enter got %b want 1", bus.snoozing); end
        checks++; if (bus.snooze_count !== 3'd1) begin errors++; $display("FAIL snooze_count got %0d want 1", bus.snooze_count); end
        checks++; if (bus.alarm_sound !== 1'b0) begin errors++; $display("FAIL snooze_silent got %b want 0", bus.alarm_sound); end
        minute_ticks(4);
        checks++; if (bus.snoozing !== 1'b1) begin errors++; $display("FAIL snooze_4min got %b want 1", bus.snoozing); end
        minute_ticks(1);
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL snooze_return got %b want 1", bus.ringing); end
        checks++; if (bus.snooze_count !== 3'd1) begin errors++; $display("FAIL snooze_keep_count got %0d want 1", bus.snooze_count); end
    endtask

    task automatic test_limit();
        for (int k = 2; k <= 3; k++) begin
            bus.snooze_button = 1'b1;
            step();
            bus.snooze_button = 1'b0;
            checks++; if (bus.snooze_count !== 3'(k)) begin errors++; $display("FAIL limit_count got %0d want %0d", bus.snooze_count, k); end
            minute_ticks(5);
            checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL limit_return got %b want 1", bus.ringing); end
        end
        step();
        bus.snooze_button = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL limit_fourth_ring got %b want 1", bus.ringing); end
        checks++; if (bus.snooze_count !== 3'd3) begin errors++; $display("FAIL limit_fourth_count got %0d want 3", bus.snooze_count); end
        for (int i = 0; i < 59; i++) begin
            bus.one_second = 1'b1;
            step();
            bus.one_second = 1'b0;
            step();
        end
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL timeout_59 got %b want 1", bus.ringing); end
        bus.one_second = 1'b1;
        step();
        bus.one_second = 1'b0;
        checks++; if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0) begin errors++; $display("FAIL timeout_idle got ring %b snz %b want 0 0", bus.ringing, bus.snoozing); end
        checks++; if (bus.snooze_count !== 3'd0) begin errors++; $display("FAIL timeout_count got %0d want 0", bus.snooze_count); end
        step();
    endtask

    task automatic test_priority();
        ring_up();
        bus.snooze_button = 1'b1;
        bus.stop_button   = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b0;
        checks++; if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0) begin errors++; $display("FAIL prio_stop_wins got ring %b snz %b want 0 0", bus.ringing, bus.snoozing); end
        step();
        ring_up();
        bus.snooze_button = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        checks++; if (bus.snoozing !== 1'b1) begin errors++; $display("FAIL prio_snooze got %b want 1", bus.snoozing); end
        bus.alarm_arm = 1'b0;
        step();
        checks++; if (bus.snoozing !== 1'b0 || bus.ringing !== 1'b0) begin errors++; $display("FAIL prio_disarm got snz %b ring %b want 0 0", bus.snoozing, bus.ringing); end
        bus.alarm_arm = 1'b1;
        step();
        ring_up();
        bus.snooze_button = 1'b1;
        step();
        minute_ticks(5);
        step();
        step();
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL held_ringing got %b want 1", bus.ringing); end
        checks++; if (bus.snooze_count !== 3'd1) begin errors++; $display("FAIL held_count got %0d want 1", bus.snooze_count); end
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b1;
        step();
        bus.stop_button   = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        ring_up();
        bus.snooze_button = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        minute_ticks(5);
        bus.snooze_button = 1'b1;
        step();
        bus.snooze_button = 1'b0;
        checks++; if (bus.snoozing !== 1'b1 || bus.snooze_count !== 3'd2) begin errors++; $display("FAIL mid_setup got snz %b cnt %0d want 1 2", bus.snoozing, bus.snooze_count); end
        reset = 1'b1;
        bus.alarm_arm = 1'b0;
        step();
        checks++; if ({bus.alarm_sound, bus.ringing, bus.snoozing, bus.snooze_count} !== 6'd0) begin
            errors++; $display("FAIL mid_reset_outputs got %b want 000000", {bus.alarm_sound, bus.ringing, bus.snoozing, bus.snooze_count});
        end
        reset = 1'b0;
        step();
        bus.alarm_arm = 1'b1;
        step();
        step();
        checks++; if (bus.ringing !== 1'b0) begin errors++; $display("FAIL mid_no_retrigger got %b want 0", bus.ringing); end
    endtask

    task automatic test_beep();
        logic beep_en;
        logic exp_sound;
`ifdef ACLK_ALARM_BEEP_EN
        beep_en = 1'b1;
`else
        beep_en = 1'b0;
`endif
        ring_up();
        exp_sound = 1'b1;
        checks++; if (bus.alarm_sound !== exp_sound) begin errors++; $display("FAIL beep_entry got %b want %b", bus.alarm_sound, exp_sound); end
        for (int i = 0; i < 4; i++) begin
            bus.one_second = 1'b1;
            step();
            bus.one_second = 1'b0;
            if (beep_en) exp_sound = ~exp_sound;
            checks++; if (bus.alarm_sound !== exp_sound || bus.ringing !== 1'b1) begin
                errors++; $display("FAIL beep_tick%0d got snd %b ring %b want %b 1", i, bus.alarm_sound, bus.ringing, exp_sound);
            end
            step();
        end
        bus.stop_button = 1'b1;
        step();
        bus.stop_button = 1'b0;
        checks++; if (bus.alarm_sound !== 1'b0) begin errors++; $display("FAIL beep_stop got %b want 0", bus.alarm_sound); end
        step();
    endtask

    initial begin
        reset             = 1'b1;
        bus.one_second    = 1'b0;
        bus.one_minute    = 1'b0;
        bus.alarm_arm     = 1'b0;
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b0;
        set_current(4'd0, 4'd0, 4'd0, 4'd0);
        bus.alarm_time_ms_hr  = 4'd0;
        bus.alarm_time_ls_hr  = 4'd7;
        bus.alarm_time_ms_min = 4'd3;
        bus.alarm_time_ls_min = 4'd0;
        test_reset();
        test_basic();
        test_snooze();
        test_limit();
        test_priority();
        test_reset_mid();
        test_beep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
